// File: rtl/spi_slave_mode_handler.sv
// SPI slave command handler: runtime SPI mode 0-3, MSB/LSB-first, preload buffer with optional wrap,
// and an RX FIFO feeding the upload arbiter. All SPI pins are oversampled in the clk domain.
module spi_slave_mode_handler #(
  parameter int         TX_DEPTH      = 256,
  parameter int         RX_DEPTH      = 64,
  parameter logic [7:0] FILL_BYTE     = 8'hFF,
  parameter logic [7:0] UPLOAD_SOURCE = 8'h15,
  parameter logic [3:0] DEFAULT_CFG   = 4'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  cmd_type,
  input  logic [15:0] cmd_length,
  input  logic [7:0]  cmd_data,
  input  logic [15:0] cmd_data_index,
  input  logic        cmd_start,
  input  logic        cmd_data_valid,
  input  logic        cmd_done,
  output logic        cmd_ready,
  input  logic        spi_clk,
  input  logic        spi_cs_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        upload_active,
  output logic        upload_req,
  output logic        upload_valid,
  output logic [7:0]  upload_data,
  output logic [7:0]  upload_source,
  input  logic        upload_ready
);
  localparam int TAW = $clog2(TX_DEPTH);
  localparam int TLW = TAW + 1;
  localparam int RAW = $clog2(RX_DEPTH);
  localparam int RCW = RAW + 1;
  localparam logic [16:0] TXD = 17'(TX_DEPTH);

  typedef enum logic {C_IDLE, C_BUSY} cstate_t;

  cstate_t          cstate, cstate_nx;
  logic [7:0]       op;
  logic             upload_en, ovf;
  logic [3:0]       cfg;
  logic [TLW-1:0]   tx_len;
  logic [7:0]       tx_buf [TX_DEPTH];

  logic [2:0]       sclk_s, cs_s;
  logic [1:0]       mosi_s;
  logic             cs_hi, cs_fall, sclk_rise, sclk_fall, smp, shf;
  logic             cpol, cpha, lsb, wrap;

  logic [TLW-1:0]   tx_ptr, ptr_inc, nxt_ptr;
  logic [7:0]       tx_byte, nxt_byte, first_byte, rx_sh, rx_nx, rx_byte;
  logic [2:0]       tx_bit, rx_cnt;
  logic             miso_q, rx_push, first_bit, cur_bit;

  logic [7:0]       fifo [RX_DEPTH];
  logic [RAW-1:0]   wr_ptr, rd_ptr;
  logic [RCW-1:0]   cnt;
  logic             push, pop, full, acc;

  logic             start_acc, dv, ovf_clr, flush;

  assign {wrap, lsb, cpol, cpha} = cfg;

  // ---------------- command bus ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) cstate <= C_IDLE;
    else        cstate <= cstate_nx;
  end

  always_comb begin
    cstate_nx = cstate;
    cmd_ready = 1'b0;
    case (cstate)
      C_IDLE: begin
        cmd_ready = cs_hi;
        if (cmd_start && cs_hi) cstate_nx = C_BUSY;
      end
      C_BUSY: if (cmd_done) cstate_nx = C_IDLE;
      default: cstate_nx = C_IDLE;
    endcase
  end

  assign start_acc = (cstate == C_IDLE) && cs_hi && cmd_start;
  assign dv        = (cstate == C_BUSY) && cmd_data_valid;
  assign ovf_clr   = start_acc && (cmd_type == 8'h15);
  assign flush     = dv && (op == 8'h15) && !cmd_data[0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op        <= 8'h00;
      upload_en <= 1'b0;
      cfg       <= DEFAULT_CFG;
      tx_len    <= '0;
    end else begin
      if (start_acc) begin
        op <= cmd_type;
        if (cmd_type == 8'h14)
          tx_len <= ({1'b0, cmd_length} > TXD) ? TLW'(TX_DEPTH) : cmd_length[TLW-1:0];
      end
      if (dv) begin
        case (op)
          8'h15:   upload_en <= cmd_data[0];
          8'h16:   cfg       <= cmd_data[3:0];
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (dv && (op == 8'h14) && ({1'b0, cmd_data_index} < TXD))
      tx_buf[cmd_data_index[TAW-1:0]] <= cmd_data;
  end

  // ---------------- SPI front end ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_s <= 3'b000;
      cs_s   <= 3'b111;
      mosi_s <= 2'b00;
    end else begin
      sclk_s <= {sclk_s[1:0], spi_clk};
      cs_s   <= {cs_s[1:0], spi_cs_n};
      mosi_s <= {mosi_s[0], spi_mosi};
    end
  end

  assign cs_hi     = cs_s[1];
  assign cs_fall   = cs_s[2] && !cs_s[1];
  assign sclk_rise = sclk_s[1] && !sclk_s[2];
  assign sclk_fall = !sclk_s[1] && sclk_s[2];
  assign smp = !cs_hi && !cs_fall && ((cpol == cpha) ? sclk_rise : sclk_fall);
  assign shf = !cs_hi && !cs_fall && ((cpol == cpha) ? sclk_fall : sclk_rise);

  assign ptr_inc    = tx_ptr + TLW'(1);
  assign first_byte = (tx_len == '0) ? FILL_BYTE : tx_buf[0];
  assign first_bit  = lsb ? first_byte[0] : first_byte[7];
  assign cur_bit    = lsb ? tx_byte[tx_bit] : tx_byte[~tx_bit];
  assign rx_nx      = lsb ? {mosi_s[1], rx_sh[7:1]} : {rx_sh[6:0], mosi_s[1]};

  // Exhausted without wrap: pointer parks at tx_len so FILL_BYTE keeps coming.
  always_comb begin
    nxt_ptr  = ptr_inc;
    nxt_byte = FILL_BYTE;
    if (ptr_inc < tx_len) begin
      nxt_byte = tx_buf[ptr_inc[TAW-1:0]];
    end else if (wrap && (tx_len != '0)) begin
      nxt_ptr  = '0;
      nxt_byte = tx_buf[0];
    end else begin
      nxt_ptr  = tx_len;
    end
  end

  // tx_bit points at the next bit to drive; CPHA=0 drives bit 0 straight from CS fall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_ptr  <= '0;
      tx_byte <= FILL_BYTE;
      tx_bit  <= 3'd0;
      rx_cnt  <= 3'd0;
      rx_sh   <= 8'h00;
      rx_byte <= 8'h00;
      rx_push <= 1'b0;
      miso_q  <= 1'b1;
    end else begin
      rx_push <= 1'b0;
      if (cs_hi) begin
        rx_cnt <= 3'd0;
        miso_q <= 1'b1;
      end else if (cs_fall) begin
        tx_ptr  <= '0;
        tx_byte <= first_byte;
        rx_cnt  <= 3'd0;
        if (cpha) begin
          tx_bit <= 3'd0;
        end else begin
          tx_bit <= 3'd1;
          miso_q <= first_bit;
        end
      end else if (smp) begin
        rx_sh  <= rx_nx;
        rx_cnt <= rx_cnt + 3'd1;
        if (rx_cnt == 3'd7) begin
          rx_push <= 1'b1;
          rx_byte <= rx_nx;
          tx_ptr  <= nxt_ptr;
          tx_byte <= nxt_byte;
          tx_bit  <= 3'd0;
        end
      end else if (shf) begin
        miso_q <= cur_bit;
        tx_bit <= tx_bit + 3'd1;
      end
    end
  end

  assign spi_miso = cs_hi | miso_q;

  // ---------------- RX FIFO / upload ----------------
  assign full = (cnt == RCW'(RX_DEPTH));
  assign push = rx_push && upload_en;
  assign pop  = upload_valid && upload_ready;
  assign acc  = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (acc) wr_ptr <= wr_ptr + RAW'(1);
        if (pop) rd_ptr <= rd_ptr + RAW'(1);
        cnt <= cnt + RCW'(acc) - RCW'(pop);
      end
      if (push && full && !pop) ovf <= 1'b1;
      if (ovf_clr)              ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (acc) fifo[wr_ptr] <= rx_byte;
  end

  assign upload_valid  = upload_en && (cnt != '0);
  assign upload_req    = upload_valid;
  assign upload_active = upload_valid;
  assign upload_data   = upload_valid ? fifo[rd_ptr] : 8'h00;
  assign upload_source = UPLOAD_SOURCE;

endmodule

// File: tb/tb_spi_slave_mode_handler.sv
// Directed bench for spi_slave_mode_handler: a vector table of preload/readback frames across modes,
// plus hand sequences for upload, LSB-first, overflow, partial bytes and mid-frame reset.
module tb_spi_slave_mode_handler;
  logic        clk, rst_n;
  logic [7:0]  cmd_type, cmd_data;
  logic [15:0] cmd_length, cmd_data_index;
  logic        cmd_start, cmd_data_valid, cmd_done, cmd_ready;
  logic        spi_clk, spi_cs_n, spi_mosi, spi_miso;
  logic        upload_active, upload_req, upload_valid, upload_ready;
  logic [7:0]  upload_data, upload_source;

  spi_slave_mode_handler #(.TX_DEPTH(16), .RX_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_type(cmd_type), .cmd_length(cmd_length), .cmd_data(cmd_data),
    .cmd_data_index(cmd_data_index), .cmd_start(cmd_start),
    .cmd_data_valid(cmd_data_valid), .cmd_done(cmd_done), .cmd_ready(cmd_ready),
    .spi_clk(spi_clk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .upload_active(upload_active), .upload_req(upload_req), .upload_valid(upload_valid),
    .upload_data(upload_data), .upload_source(upload_source), .upload_ready(upload_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  logic [7:0] up_q[$];
  int src_bad = 0;
  always @(negedge clk) begin
    if (rst_n && upload_valid && upload_ready) begin
      up_q.push_back(upload_data);
      if (upload_source != 8'h15) src_bad++;
    end
  end

  localparam int H = 8;  // clk cycles per SPI half period
  task automatic hwait;
    repeat (H) @(posedge clk);
    #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [7:0] op, input int len, input logic [63:0] d);
    int t;
    t = 0;
    while (!cmd_ready && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (!cmd_ready) chk("cmd_ready_timeout", {31'b0, cmd_ready}, 1);
    cmd_type   = op;
    cmd_length = len[15:0];
    cmd_start  = 1'b1;
    @(posedge clk); #1;
    cmd_start = 1'b0;
    chk("cmd_ready_busy", {31'b0, cmd_ready}, 0);
    for (int i = 0; i < len && i < 8; i++) begin
      cmd_data       = d[63-8*i -: 8];
      cmd_data_index = i[15:0];
      cmd_data_valid = 1'b1;
      @(posedge clk); #1;
    end
    cmd_data_valid = 1'b0;
    cmd_done = 1'b1;
    @(posedge clk); #1;
    cmd_done = 1'b0;
    chk("cmd_ready_after_done", {31'b0, cmd_ready}, 1);
  endtask

  logic [63:0] mtx, mrx;
  // Master is always MSB-first; lastbits < 8 truncates the final byte.
  task automatic spi_frame(input int nbytes, input int lastbits, input logic [1:0] mode);
    logic cpol, cpha, bv;
    int nb, idx;
    cpol = mode[1];
    cpha = mode[0];
    spi_clk = cpol;
    hwait;
    spi_cs_n = 1'b0;
    hwait;
    mrx = '0;
    for (int b = 0; b < nbytes; b++) begin
      nb = (b == nbytes - 1) ? lastbits : 8;
      for (int i = 0; i < nb; i++) begin
        idx = 63 - 8*b - i;
        bv  = mtx[idx];
        if (!cpha) begin
          spi_mosi = bv;
          hwait;
          spi_clk = ~cpol;
          mrx[idx] = spi_miso;
          hwait;
          spi_clk = cpol;
        end else begin
          spi_clk  = ~cpol;
          spi_mosi = bv;
          hwait;
          spi_clk = cpol;
          mrx[idx] = spi_miso;
          hwait;
        end
      end
    end
    hwait;
    spi_cs_n = 1'b1;
    hwait;
    hwait;
  endtask

  typedef struct {
    logic [3:0]  cfg;
    int          npre;
    logic [63:0] pre;
    int          nrd;
    logic [63:0] exp;
  } vec_t;
  vec_t tbl[7];

  initial begin
    #2ms;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    tbl[0] = '{4'h1, 8, 64'h4650474132303235, 8, 64'h4650474132303235};
    tbl[1] = '{4'h2, 8, 64'h4650474132303235, 8, 64'h4650474132303235};
    tbl[2] = '{4'h3, 8, 64'h4650474132303235, 8, 64'h4650474132303235};
    tbl[3] = '{4'h0, 3, 64'h1122330000000000, 5, 64'h112233FFFF000000};
    tbl[4] = '{4'h8, 3, 64'h1122330000000000, 5, 64'h1122331122000000};
    tbl[5] = '{4'h4, 1, 64'h0100000000000000, 1, 64'h8000000000000000};
    tbl[6] = '{4'h0, 0, 64'h0,                2, 64'hFFFF000000000000};

    rst_n = 1'b0;
    cmd_type = 8'h00; cmd_length = 16'h0; cmd_data = 8'h00; cmd_data_index = 16'h0;
    cmd_start = 1'b0; cmd_data_valid = 1'b0; cmd_done = 1'b0;
    spi_clk = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0; upload_ready = 1'b0;
    mtx = '0;
    cycles(3);

    chk("rst_cmd_ready", {31'b0, cmd_ready}, 1);
    chk("rst_miso", {31'b0, spi_miso}, 1);
    chk("rst_upload_valid", {31'b0, upload_valid}, 0);
    chk("rst_upload_req", {31'b0, upload_req}, 0);
    chk("rst_upload_active", {31'b0, upload_active}, 0);
    chk("rst_upload_data", {24'b0, upload_data}, 0);
    chk("rst_upload_source", {24'b0, upload_source}, 32'h15);
    chk("rst_ovf", {31'b0, dut.ovf}, 0);
    rst_n = 1'b1;
    cycles(4);

    // preload/readback table (upload disabled, so MOSI data is discarded)
    for (int v = 0; v < 7; v++) begin
      send_cmd(8'h16, 1, {4'h0, tbl[v].cfg, 56'h0});
      send_cmd(8'h14, tbl[v].npre, tbl[v].pre);
      mtx = '0;
      spi_frame(tbl[v].nrd, 8, tbl[v].cfg[1:0]);
      for (int b = 0; b < tbl[v].nrd; b++)
        chk($sformatf("vec%0d_byte%0d", v, b), {24'b0, mrx[63-8*b -: 8]},
            {24'b0, tbl[v].exp[63-8*b -: 8]});
    end
    chk("table_no_upload", up_q.size(), 0);

    // mode 0 upload of AA BB CC DD
    send_cmd(8'h16, 1, 64'h0);
    upload_ready = 1'b1;
    send_cmd(8'h15, 1, {8'h01, 56'h0});
    up_q.delete();
    mtx = {32'hAABBCCDD, 32'h0};
    spi_frame(4, 8, 2'd0);
    cycles(20);
    chk("up_count", up_q.size(), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("up_byte%0d", i), {24'b0, up_q[i]}, {24'b0, mtx[63-8*i -: 8]});
    chk("up_source", src_bad, 0);
    chk("up_ovf", {31'b0, dut.ovf}, 0);

    // LSB-first receive
    send_cmd(8'h16, 1, {8'h04, 56'h0});
    up_q.delete();
    mtx = {8'h01, 56'h0};
    spi_frame(1, 8, 2'd0);
    cycles(20);
    chk("lsb_count", up_q.size(), 1);
    chk("lsb_byte", {24'b0, up_q[0]}, 32'h80);

    // overflow: 6 bytes into a 4-deep FIFO with the arbiter stalled
    send_cmd(8'h16, 1, 64'h0);
    upload_ready = 1'b0;
    up_q.delete();
    mtx = {48'h010203040506, 16'h0};
    spi_frame(6, 8, 2'd0);
    cycles(20);
    chk("ovf_valid", {31'b0, upload_valid}, 1);
    chk("ovf_set", {31'b0, dut.ovf}, 1);
    chk("ovf_held_count", up_q.size(), 0);
    upload_ready = 1'b1;
    cycles(20);
    chk("ovf_drain_count", up_q.size(), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("ovf_byte%0d", i), {24'b0, up_q[i]}, i + 1);
    chk("ovf_drained_valid", {31'b0, upload_valid}, 0);
    chk("ovf_sticky", {31'b0, dut.ovf}, 1);
    send_cmd(8'h15, 1, {8'h01, 56'h0});
    chk("ovf_cleared", {31'b0, dut.ovf}, 0);

    // CS raised after 5 bits discards the partial byte; next byte starts aligned
    up_q.delete();
    mtx = {8'hFF, 56'h0};
    spi_frame(1, 5, 2'd0);
    cycles(20);
    chk("partial_count", up_q.size(), 0);
    mtx = {8'h3C, 56'h0};
    spi_frame(1, 8, 2'd0);
    cycles(20);
    chk("after_partial_count", up_q.size(), 1);
    chk("after_partial_byte", {24'b0, up_q[0]}, 32'h3C);

    // reset mid-frame with a byte waiting in the FIFO
    upload_ready = 1'b0;
    mtx = {8'h5A, 56'h0};
    spi_frame(1, 8, 2'd0);
    cycles(10);
    chk("pre_rst_valid", {31'b0, upload_valid}, 1);
    send_cmd(8'h14, 1, 64'h0);
    spi_cs_n = 1'b0;
    hwait;
    chk("pre_rst_miso", {31'b0, spi_miso}, 0);
    chk("pre_rst_cmd_ready", {31'b0, cmd_ready}, 0);
    spi_mosi = 1'b1;
    spi_clk  = 1'b1;
    hwait;
    spi_clk = 1'b0;
    hwait;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_cmd_ready", {31'b0, cmd_ready}, 1);
    chk("mid_rst_miso", {31'b0, spi_miso}, 1);
    chk("mid_rst_upload_valid", {31'b0, upload_valid}, 0);
    chk("mid_rst_upload_req", {31'b0, upload_req}, 0);
    chk("mid_rst_upload_active", {31'b0, upload_active}, 0);
    chk("mid_rst_upload_data", {24'b0, upload_data}, 0);
    chk("mid_rst_upload_source", {24'b0, upload_source}, 32'h15);
    chk("mid_rst_upload_en", {31'b0, dut.upload_en}, 0);
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    cycles(2);
    rst_n = 1'b1;
    cycles(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
